// File: rtl/ts_frame_arbiter.sv
// Round-robin frame arbiter: grants one TS source at a time and forwards its frame (sof..eof).
// Define TS_ARB_STAT_EN to add the frame_cnt / miss_cnt statistics outputs.
module ts_frame_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int GRANT_WAIT = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [64*NUM_SRC-1:0]  src_data,
  input  logic [8*NUM_SRC-1:0]   src_mask,
  input  logic [NUM_SRC-1:0]     src_en,
  input  logic [NUM_SRC-1:0]     src_sof,
  input  logic [NUM_SRC-1:0]     src_eof,
  output logic [NUM_SRC-1:0]     src_hold,
  input  logic                   tx_over_full,
  output logic [63:0]            ts_dout,
  output logic [7:0]             ts_mask,
  output logic                   ts_dout_en,
  output logic                   ts_sof,
  output logic                   ts_eof,
  output logic [2:0]             cur_src,
`ifdef TS_ARB_STAT_EN
  output logic                   drop_err,
  output logic [31:0]            frame_cnt,
  output logic [15:0]            miss_cnt
`else
  output logic                   drop_err
`endif
);

  localparam logic [2:0] LAST_SRC = 3'(NUM_SRC - 1);
  localparam logic [3:0] GW       = 4'(GRANT_WAIT);
  localparam logic [3:0] GC       = 4'(GAP_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_WAIT_SOF,
    S_STREAM,
    S_GAP
  } state_t;

  state_t             r_state;
  logic [2:0]         r_ptr;
  logic [2:0]         r_cur;
  logic [3:0]         r_wcnt;
  logic [3:0]         r_gcnt;
  logic [NUM_SRC-1:0] r_hold;
  logic [63:0]        r_dout;
  logic [7:0]         r_mask;
  logic               r_en;
  logic               r_sof;
  logic               r_eof;
  logic               r_drop;
`ifdef TS_ARB_STAT_EN
  logic [31:0]        r_frame_cnt;
  logic [15:0]        r_miss_cnt;
`endif

  logic [63:0]        w_sel_data;
  logic [7:0]         w_sel_mask;
  logic               w_sel_en;
  logic               w_sel_sof;
  logic               w_sel_eof;
  logic [NUM_SRC-1:0] w_ok;
  logic [NUM_SRC-1:0] w_grant_hold;
  logic               w_window;
  logic               w_drop;
  logic               w_fwd;
  logic [2:0]         w_next;

  always_comb begin
    w_sel_data   = '0;
    w_sel_mask   = '0;
    w_sel_en     = 1'b0;
    w_sel_sof    = 1'b0;
    w_sel_eof    = 1'b0;
    w_ok         = '0;
    w_grant_hold = '1;
    w_window     = (r_state == S_WAIT_SOF) || (r_state == S_STREAM);
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (r_cur == 3'(i)) begin
        w_sel_data = src_data[64*i +: 64];
        w_sel_mask = src_mask[8*i +: 8];
        w_sel_en   = src_en[i];
        w_sel_sof  = src_sof[i];
        w_sel_eof  = src_eof[i];
        w_ok[i]    = w_window;
      end
      if (r_ptr == 3'(i)) w_grant_hold[i] = 1'b0;
    end
  end

  // Any beat outside the selected source's open window is discarded and flagged.
  assign w_drop = |(src_en & ~w_ok);
  assign w_fwd  = w_sel_en && ((r_state == S_STREAM) ||
                               ((r_state == S_WAIT_SOF) && w_sel_sof));
  assign w_next = (r_cur == LAST_SRC) ? '0 : r_cur + 3'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_cur       <= '0;
      r_wcnt      <= '0;
      r_gcnt      <= '0;
      r_hold      <= '1;
      r_dout      <= '0;
      r_mask      <= '0;
      r_en        <= 1'b0;
      r_sof       <= 1'b0;
      r_eof       <= 1'b0;
      r_drop      <= 1'b0;
`ifdef TS_ARB_STAT_EN
      r_frame_cnt <= '0;
      r_miss_cnt  <= '0;
`endif
    end else begin
      r_en  <= w_fwd;
      r_sof <= w_fwd & w_sel_sof;
      r_eof <= w_fwd & w_sel_eof;
      if (w_fwd) begin
        r_dout <= w_sel_data;
        r_mask <= w_sel_mask;
      end
      if (w_drop) r_drop <= 1'b1;
`ifdef TS_ARB_STAT_EN
      if (w_fwd && w_sel_eof) r_frame_cnt <= r_frame_cnt + 32'd1;
`endif
      unique case (r_state)
        S_IDLE: begin
          if (!tx_over_full) begin
            r_state <= S_GRANT;
            r_cur   <= r_ptr;
            r_hold  <= w_grant_hold;
          end
        end
        // Pointer advances on every grant, so hits and misses rotate identically.
        S_GRANT: begin
          r_hold  <= '1;
          r_ptr   <= w_next;
          r_wcnt  <= 4'd1;
          r_state <= S_WAIT_SOF;
        end
        S_WAIT_SOF: begin
          if (w_fwd) begin
            r_gcnt  <= 4'd1;
            r_state <= w_sel_eof ? S_GAP : S_STREAM;
          end else if (r_wcnt >= GW) begin
            r_state <= S_IDLE;
`ifdef TS_ARB_STAT_EN
            if (r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 16'd1;
`endif
          end else begin
            r_wcnt <= r_wcnt + 4'd1;
          end
        end
        S_STREAM: begin
          if (w_fwd && w_sel_eof) begin
            r_gcnt  <= 4'd1;
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          if (r_gcnt >= GC) r_state <= S_IDLE;
          else              r_gcnt  <= r_gcnt + 4'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign src_hold   = r_hold;
  assign ts_dout    = r_dout;
  assign ts_mask    = r_mask;
  assign ts_dout_en = r_en;
  assign ts_sof     = r_sof;
  assign ts_eof     = r_eof;
  assign cur_src    = r_cur;
  assign drop_err   = r_drop;
`ifdef TS_ARB_STAT_EN
  assign frame_cnt  = r_frame_cnt;
  assign miss_cnt   = r_miss_cnt;
`endif

endmodule

// File: tb/tb_ts_frame_arbiter.sv
// Scoreboard bench for ts_frame_arbiter: source models push expected beats, a negedge monitor pops them.
module tb_ts_frame_arbiter;
  localparam int NS  = 4;
  localparam int GW  = 4;
  localparam int GAP = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [64*NS-1:0]  src_data = '0;
  logic [8*NS-1:0]   src_mask = '0;
  logic [NS-1:0]     src_en = '0;
  logic [NS-1:0]     src_sof = '0;
  logic [NS-1:0]     src_eof = '0;
  logic [NS-1:0]     src_hold;
  logic              tx_over_full = 1'b0;
  logic [63:0]       ts_dout;
  logic [7:0]        ts_mask;
  logic              ts_dout_en, ts_sof, ts_eof;
  logic [2:0]        cur_src;
  logic              drop_err;
`ifdef TS_ARB_STAT_EN
  logic [31:0]       frame_cnt;
  logic [15:0]       miss_cnt;
`endif

  ts_frame_arbiter #(.NUM_SRC(NS), .GRANT_WAIT(GW), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset),
    .src_data(src_data), .src_mask(src_mask), .src_en(src_en),
    .src_sof(src_sof), .src_eof(src_eof), .src_hold(src_hold),
    .tx_over_full(tx_over_full),
    .ts_dout(ts_dout), .ts_mask(ts_mask), .ts_dout_en(ts_dout_en),
    .ts_sof(ts_sof), .ts_eof(ts_eof), .cur_src(cur_src),
`ifdef TS_ARB_STAT_EN
    .drop_err(drop_err), .frame_cnt(frame_cnt), .miss_cnt(miss_cnt)
`else
    .drop_err(drop_err)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  m;
    logic        s;
    logic        e;
    logic [2:0]  src;
    logic [31:0] cyc;
  } beat_t;

  beat_t expq[$];
  int    total = 0;
  int    bad = 0;
  int    nframes = 0;
  int    ord[$];
  int    grants[$];
  int    gtime[$];
  int    miss_at_grant[$];
  int    last_eof = -1;
  int    beats_in_frame = 0;
  int    last_frame_len = 0;

  int    s_ans[NS];
  int    s_len[NS];
  int    s_delay[NS];
  int    s_beat[NS];
  int    s_frame[NS];
  bit    rogue_on = 1'b0;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: grants, output beats against the scoreboard, frame order and spacing.
  beat_t mon_e, mon_a;
  always @(negedge clk) begin
    if (!reset) begin
      if (src_hold != '1) begin
        check("hold_onehot", $countones(~src_hold), 1);
        for (int i = 0; i < NS; i++) if (!src_hold[i]) grants.push_back(i);
        gtime.push_back(int'(cyc));
`ifdef TS_ARB_STAT_EN
        miss_at_grant.push_back(int'(miss_cnt));
`endif
      end
      if (ts_dout_en) begin
        mon_a = '{d: ts_dout, m: ts_mask, s: ts_sof, e: ts_eof, src: cur_src, cyc: 32'(cyc)};
        total++;
        if (expq.size() == 0) begin
          bad++;
          $display("FAIL beat_unexpected: got d=%h src=%0d expected no beat", ts_dout, cur_src);
        end else begin
          mon_e = expq.pop_front();
          if (mon_a !== mon_e) begin
            bad++;
            $display("FAIL beat: got d=%h m=%h s=%b e=%b src=%0d cyc=%0d expected d=%h m=%h s=%b e=%b src=%0d cyc=%0d",
                     mon_a.d, mon_a.m, mon_a.s, mon_a.e, mon_a.src, mon_a.cyc,
                     mon_e.d, mon_e.m, mon_e.s, mon_e.e, mon_e.src, mon_e.cyc);
          end
        end
        if (ts_sof) begin
          beats_in_frame = 1;
          ord.push_back(int'(cur_src));
          if (last_eof >= 0) check("frame_spacing_ok", (int'(cyc) - last_eof >= 4 + GAP), 1);
        end else begin
          beats_in_frame++;
        end
        if (ts_eof) begin
          last_eof = int'(cyc);
          last_frame_len = beats_in_frame;
          nframes++;
        end
      end
    end
  end

  task automatic drive_beat(input int i);
    logic [63:0] d;
    logic [7:0]  m;
    logic        s, e;
    d = {8'(i), 8'(s_frame[i]), 16'(s_beat[i]), 32'(cyc) ^ 32'hA5C3_0F1E};
    s = (s_beat[i] == 0);
    e = (s_beat[i] == s_len[i] - 1);
    m = e ? 8'h0F : 8'hFF;
    src_data[64*i +: 64] = d;
    src_mask[8*i +: 8]   = m;
    src_en[i]  = 1'b1;
    src_sof[i] = s;
    src_eof[i] = e;
    expq.push_back('{d: d, m: m, s: s, e: e, src: 3'(i), cyc: 32'(cyc + 1)});
    s_beat[i]++;
    if (e) begin
      s_beat[i] = -1;
      s_frame[i]++;
    end
  endtask

  // One clock of source behaviour: a source seeing its hold low sends sof two cycles later.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NS; i++) begin
      src_en[i]  = 1'b0;
      src_sof[i] = 1'b0;
      src_eof[i] = 1'b0;
      if (s_beat[i] < 0 && s_delay[i] > 0) begin
        s_delay[i]--;
        if (s_delay[i] == 0) s_beat[i] = 0;
      end else if (s_beat[i] < 0 && s_ans[i] != 0 && !src_hold[i]) begin
        s_delay[i] = 2;
      end
      if (s_beat[i] >= 0) drive_beat(i);
    end
    if (rogue_on && src_en[0]) begin
      src_data[64*3 +: 64] = 64'hBAD0_BAD0_0000_0000 | 64'(cyc);
      src_mask[8*3 +: 8]   = 8'hFF;
      src_en[3]  = 1'b1;
      src_sof[3] = 1'b1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    src_en = '0; src_sof = '0; src_eof = '0;
    tx_over_full = 1'b0;
    rogue_on = 1'b0;
    for (int i = 0; i < NS; i++) begin
      s_ans[i] = 0; s_len[i] = 8; s_delay[i] = 0; s_beat[i] = -1; s_frame[i] = 0;
    end
    expq.delete(); ord.delete(); grants.delete(); gtime.delete(); miss_at_grant.delete();
    nframes = 0; last_eof = -1; beats_in_frame = 0; last_frame_len = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic run_until(input string name, input int target, input int budget);
    int n;
    n = 0;
    while (nframes < target && n < budget) begin
      tick();
      n++;
    end
    if (nframes < target) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got %0d frames expected %0d", name, nframes, target);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int exp_g[7];
    int exp_o[5];
    int n;

    // Reset state
    do_reset();
    check("rst_hold", src_hold, 4'hF);
    check("rst_dout", ts_dout, 0);
    check("rst_ctl", {ts_mask, ts_dout_en, ts_sof, ts_eof, cur_src, drop_err}, 0);
`ifdef TS_ARB_STAT_EN
    check("rst_stat", {frame_cnt, miss_cnt}, 0);
`endif

    // Single 25-beat frame from source 1 (source 0 polled and missed first)
    s_ans[1] = 1; s_len[1] = 25;
    run_until("single", 1, 300);
    s_ans[1] = 0;
    check("single_len", last_frame_len, 25);
    check("single_src", ord[0], 1);
    check("single_grant0", grants[0], 0);
    check("single_grant1", grants[1], 1);
    check("single_drop", drop_err, 0);
    repeat (3) tick();
    check("single_q_empty", expq.size(), 0);

    // Round robin, all sources ready
    do_reset();
    for (int i = 0; i < NS; i++) begin s_ans[i] = 1; s_len[i] = 10; end
    run_until("rr", 5, 500);
    for (int i = 0; i < NS; i++) s_ans[i] = 0;
    exp_o = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) check($sformatf("rr_order%0d", i), ord[i], exp_o[i]);
    repeat (3) tick();
    check("rr_q_empty", expq.size(), 0);

    // Poll miss: only source 2 answers
    do_reset();
    s_ans[2] = 1; s_len[2] = 6;
    run_until("miss", 2, 500);
    s_ans[2] = 0;
    exp_g = '{0, 1, 2, 3, 0, 1, 2};
    check("miss_ngrants", grants.size(), 7);
    for (int i = 0; i < 7; i++) check($sformatf("miss_grant%0d", i), grants[i], exp_g[i]);
    check("miss_interval0", gtime[1] - gtime[0], 2 + GW);
    check("miss_interval3", gtime[4] - gtime[3], 2 + GW);
    check("miss_only_src2", ord[0] * 16 + ord[1], 8'h22);
`ifdef TS_ARB_STAT_EN
    check("miss_cnt_round", miss_at_grant[4], 3);
    check("miss_cnt_end", miss_cnt, 5);
    check("frame_cnt_end", frame_cnt, 2);
`endif

    // Backpressure: no grant while full in IDLE, full mid-stream does not truncate
    do_reset();
    tx_over_full = 1'b1;
    s_ans[0] = 1; s_len[0] = 12;
    repeat (20) tick();
    check("bp_no_grant", grants.size(), 0);
    check("bp_hold", src_hold, 4'hF);
    tx_over_full = 1'b0;
    n = 0;
    while (nframes < 1 && n < 200) begin
      tick();
      if (s_beat[0] == 5) tx_over_full = 1'b1;
      n++;
    end
    check("bp_frame_done", nframes, 1);
    check("bp_len", last_frame_len, 12);
    repeat (15) tick();
    check("bp_no_regrant", grants.size(), 1);
    check("bp_q_empty", expq.size(), 0);

    // Rogue source 3 transmits while source 0 streams
    do_reset();
    s_ans[0] = 1; s_len[0] = 12;
    rogue_on = 1'b1;
    n = 0;
    while (!src_en[0] && n < 50) begin
      tick();
      n++;
    end
    check("rogue_pre_drop", drop_err, 0);
    run_until("rogue", 1, 100);
    s_ans[0] = 0;
    check("rogue_drop", drop_err, 1);
    repeat (20) tick();
    check("rogue_drop_sticky", drop_err, 1);
    check("rogue_q_empty", expq.size(), 0);

    // Reset asserted on beat 5 of a frame from source 1
    do_reset();
    s_ans[1] = 1; s_len[1] = 20;
    n = 0;
    while (s_beat[1] != 5 && n < 100) begin
      tick();
      n++;
    end
    check("midrst_pre_en", ts_dout_en, 1);
    reset = 1'b1;
    #1;
    check("midrst_hold", src_hold, 4'hF);
    check("midrst_dout", ts_dout, 0);
    check("midrst_ctl", {ts_mask, ts_dout_en, ts_sof, ts_eof, cur_src, drop_err}, 0);
    do_reset();
    s_ans[0] = 1; s_len[0] = 4;
    run_until("midrst", 1, 100);
    s_ans[0] = 0;
    check("midrst_next_grant", grants[0], 0);
    check("midrst_next_src", ord[0], 0);
    check("midrst_drop", drop_err, 0);
    repeat (3) tick();
    check("final_q_empty", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
